// File: rtl/mips32_fetch_queue_pkg.sv
// Shared MIPS32 definitions: opcodes, instruction classes, fetch-queue types.
// Pure declarations, no timing.
// No handshake lives here.
package mips32_pkg;

  // Opcode field [31:26]
  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  typedef enum logic [2:0] {
    ITYPE_RR_ALU,
    ITYPE_RM_ALU,
    ITYPE_LOAD,
    ITYPE_STORE,
    ITYPE_BRANCH,
    ITYPE_HALT
  } instr_type_t;

  typedef enum logic {
    RUN,
    STOPPED
  } fq_state_t;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] npc;
  } fq_entry_t;

  function automatic logic is_hlt(input logic [31:0] ir);
    return ir[31:26] == OP_HLT;
  endfunction

endpackage

// File: rtl/mips32_fetch_queue_if.sv
// Fetch-queue buses: instruction-memory read port and decode valid/ready port.
// Memory data returns one cycle after the request.
// Decode side holds head stable while out_valid=1 and out_ready=0.
interface mips32_fetch_queue_if #(
  parameter int ADDR_W = 10
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              out_valid;
  logic [31:0]       out_ir;
  logic [31:0]       out_npc;
  logic              out_ready;

  // Fetch-queue side
  modport master (
    output imem_req, imem_addr,
    input  imem_rdata,
    output out_valid, out_ir, out_npc,
    input  out_ready
  );

  // Memory / decode side
  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata,
    input  out_valid, out_ir, out_npc,
    output out_ready
  );
endinterface

// File: rtl/mips32_sync_fifo.sv
// Synchronous FIFO of fetch entries with count and synchronous flush.
// Head is read combinationally; a push is visible at the head next cycle.
// No internal backpressure: caller guarantees no push when full.
module mips32_sync_fifo
  import mips32_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk1,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  fq_entry_t              push_dat_i,
  input  logic                   pop_i,
  output fq_entry_t              head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fq_entry_t              mem_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]       cnt_q;

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk1) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage array, no reset needed since occupancy guards reads
  always_ff @(posedge clk1) begin
    if (push_i && !flush_i && !rst) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/mips32_fetch_queue.sv
// MIPS32 instruction prefetch queue owning the fetch PC; optional stats via FQ_STATS_EN.
// Fetch-to-decode 2 cycles; redirect-to-target-valid 3 cycles.
// Credit based: requests stop when buffered + in-flight words reach DEPTH.
module mips32_fetch_queue
  import mips32_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic                clk1,
  input  logic                rst,
  mips32_fetch_queue_if.master bus,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  input  logic                halt,
  output logic [31:0]         fetch_pc
`ifdef FQ_STATS_EN
  ,
  output logic [15:0]         stat_flushes,
  output logic [15:0]         stat_stalls
`endif
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  fq_state_t        state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             inflight_q, inflight_d;
  logic [31:0]      npc_q, npc_d;

  logic             issue, push, pop, out_vld, hlt_push;
  logic [CNT_W-1:0] fifo_cnt, credits_used;
  logic             fifo_empty;
  fq_entry_t        head, push_ent;

  assign credits_used = fifo_cnt + CNT_W'(inflight_q);
  assign hlt_push     = push && is_hlt(bus.imem_rdata);
  assign push_ent     = '{ir: bus.imem_rdata, npc: npc_q};

  // State register
  always_ff @(posedge clk1) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Next state: redirect decides RUN/STOPPED; HLT or halt stops a running fetch
  always_comb begin
    state_d = state_q;
    if (redirect_valid)                          state_d = halt ? STOPPED : RUN;
    else if (state_q == RUN && (halt || hlt_push)) state_d = STOPPED;
  end

  // Outputs: issue gating, return acceptance (words after HLT dropped), decode handshake
  always_comb begin
    issue   = !rst && state_q == RUN && !halt && !redirect_valid
              && (credits_used < CNT_W'(DEPTH));
    push    = inflight_q && !redirect_valid && state_q == RUN;
    out_vld = !fifo_empty && !redirect_valid;
    pop     = out_vld && bus.out_ready;
  end

  // PC and in-flight tracking next state
  always_comb begin
    pc_d       = pc_q;
    npc_d      = npc_q;
    inflight_d = issue;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (issue) begin
      pc_d  = pc_q + 32'd1;
      npc_d = pc_q + 32'd1;
    end
  end

  // PC and in-flight registers
  always_ff @(posedge clk1) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      npc_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      npc_q      <= npc_d;
      inflight_q <= inflight_d;
    end
  end

  mips32_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk1       (clk1),
    .rst        (rst),
    .flush_i    (redirect_valid),
    .push_i     (push),
    .push_dat_i (push_ent),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (fifo_cnt),
    .empty_o    (fifo_empty)
  );

  assign bus.imem_req  = issue;
  assign bus.imem_addr = pc_q[ADDR_W-1:0];
  assign bus.out_valid = out_vld;
  assign bus.out_ir    = head.ir;
  assign bus.out_npc   = head.npc;
  assign fetch_pc      = pc_q;

`ifdef FQ_STATS_EN
  logic [15:0] flushes_q, stalls_q;

  // Saturating redirect and decode-starvation counters
  always_ff @(posedge clk1) begin
    if (rst) begin
      flushes_q <= '0;
      stalls_q  <= '0;
    end else begin
      if (redirect_valid && flushes_q != 16'hFFFF) flushes_q <= flushes_q + 16'd1;
      if (state_q == RUN && !out_vld && !redirect_valid && stalls_q != 16'hFFFF)
        stalls_q <= stalls_q + 16'd1;
    end
  end

  assign stat_flushes = flushes_q;
  assign stat_stalls  = stalls_q;
`endif

endmodule

// File: tb/tb_mips32_fetch_queue.sv
module tb_mips32_fetch_queue;
  logic        clk1 = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] fetch_pc;
`ifdef FQ_STATS_EN
  logic [15:0] stat_flushes, stat_stalls;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] mem [1024];
  int exp_q [$];

  mips32_fetch_queue_if #(.ADDR_W(10)) bus ();

  mips32_fetch_queue #(.DEPTH(4), .ADDR_W(10), .RESET_PC(32'd0)) dut (
    .clk1           (clk1),
    .rst            (rst),
    .bus            (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .fetch_pc       (fetch_pc)
`ifdef FQ_STATS_EN
    ,
    .stat_flushes   (stat_flushes),
    .stat_stalls    (stat_stalls)
`endif
  );

  always #5 clk1 = ~clk1;

  // Instruction memory: one-cycle read latency
  always @(posedge clk1) begin
    if (bus.imem_req) bus.imem_rdata <= mem[bus.imem_addr];
  end

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic do_reset(input bit rdy);
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
    bus.out_ready = rdy;
    exp_q.delete();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
    bus.out_ready = 1'b1;
    step();
    @(negedge clk1);
    n_cmp++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", bus.imem_req); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (fetch_pc !== 32'd0) begin n_bad++; $display("FAIL rst_pc: got %h want 0", fetch_pc); end
    step();
    rst = 1'b0;
    @(negedge clk1);
    n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 10'd0) begin
      n_bad++; $display("FAIL first_req: got req=%b addr=%0d want req=1 addr=0", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_stream();
    int first; bit ok;
    do_reset(1'b1);
    for (int a = 0; a < 8; a++) exp_q.push_back(a);
    first = -1; ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
      @(negedge clk1);
      if (bus.out_valid && first < 0) first = c;
      step();
    end
    bus.out_ready = 1'b0;
    n_cmp++; if (first != 2) begin n_bad++; $display("FAIL stream_first_valid: got cycle %0d want 2", first); end
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL stream_drain: %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int reqs; bit ok;
    do_reset(1'b0);
    reqs = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk1);
      if (bus.imem_req) reqs++;
      if (c < 19) step();
    end
    n_cmp++; if (reqs != 4) begin n_bad++; $display("FAIL bp_reqs: got %0d want 4", reqs); end
    n_cmp++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL bp_req_idle: got %b want 0", bus.imem_req); end
    n_cmp++; if (fetch_pc !== 32'd4) begin n_bad++; $display("FAIL bp_pc: got %0d want 4", fetch_pc); end
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_ir !== 32'd0 || bus.out_npc !== 32'd1) begin
      n_bad++; $display("FAIL bp_head: got v=%b ir=%h npc=%h want v=1 ir=0 npc=1", bus.out_valid, bus.out_ir, bus.out_npc);
    end
    step();
    for (int a = 0; a < 8; a++) exp_q.push_back(a);
    bus.out_ready = 1'b1;
    wait_drain(60, ok);
    bus.out_ready = 1'b0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_drain: %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_redirect();
    bit ok;
    do_reset(1'b0);
    repeat (4) step();
    redirect_valid = 1'b1; redirect_pc = 32'd100;
    @(negedge clk1);
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
      n_bad++; $display("FAIL redir_cycle: got v=%b req=%b want 0 0", bus.out_valid, bus.imem_req);
    end
    step();
    redirect_valid = 1'b0;
    @(negedge clk1);
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 10'd100) begin
      n_bad++; $display("FAIL redir_next: got v=%b req=%b addr=%0d want 0 1 100", bus.out_valid, bus.imem_req, bus.imem_addr);
    end
    step();
    @(negedge clk1);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL redir_r2: got v=%b want 0", bus.out_valid); end
    step();
    for (int a = 100; a < 104; a++) exp_q.push_back(a);
    bus.out_ready = 1'b1;
    @(negedge clk1);
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL redir_r3: got v=%b want 1", bus.out_valid); end
    step();
    wait_drain(30, ok);
    bus.out_ready = 1'b0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL redir_drain: %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_hlt();
    bit ok; int reqs, vlds;
    mem[5] = 32'hFC000000;
    do_reset(1'b1);
    for (int a = 0; a < 6; a++) exp_q.push_back(a);
    wait_drain(30, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL hlt_drain: %0d left want 0", exp_q.size()); end
    reqs = 0; vlds = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk1);
      if (bus.imem_req) reqs++;
      if (bus.out_valid) vlds++;
      step();
    end
    n_cmp++; if (reqs != 0 || vlds != 0) begin n_bad++; $display("FAIL hlt_stopped: got req=%0d valid=%0d want 0 0", reqs, vlds); end
    for (int a = 0; a < 6; a++) exp_q.push_back(a);
    redirect_valid = 1'b1; redirect_pc = 32'd0;
    step();
    redirect_valid = 1'b0;
    wait_drain(30, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL hlt_resume: %0d left want 0", exp_q.size()); end
    bus.out_ready = 1'b0;
    mem[5] = 32'd5;
  endtask

  task automatic test_halt_ext();
    bit ok; int reqs;
    do_reset(1'b1);
    for (int a = 0; a < 3; a++) exp_q.push_back(a);
    repeat (3) step();
    halt = 1'b1;
    @(negedge clk1);
    n_cmp++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL halt_req: got %b want 0", bus.imem_req); end
    step();
    wait_drain(20, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL halt_drain: %0d left want 0", exp_q.size()); end
    halt = 1'b0;
    reqs = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk1); if (bus.imem_req) reqs++;
      step();
    end
    n_cmp++; if (reqs != 0) begin n_bad++; $display("FAIL halt_sticky: got %0d reqs want 0", reqs); end
    halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'd50;
    step();
    halt = 1'b0; redirect_valid = 1'b0;
    reqs = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk1); if (bus.imem_req) reqs++;
      step();
    end
    n_cmp++; if (reqs != 0 || fetch_pc !== 32'd50) begin
      n_bad++; $display("FAIL halt_redir: got reqs=%0d pc=%0d want 0 50", reqs, fetch_pc);
    end
    for (int a = 50; a < 54; a++) exp_q.push_back(a);
    redirect_valid = 1'b1;
    step();
    redirect_valid = 1'b0;
    wait_drain(30, ok);
    bus.out_ready = 1'b0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL halt_resume: %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset(1'b0);
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk1);
    n_cmp++; if (bus.out_valid !== 1'b0 || fetch_pc !== 32'd0) begin
      n_bad++; $display("FAIL mid_rst_state: got v=%b pc=%0d want 0 0", bus.out_valid, fetch_pc);
    end
    n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 10'd0) begin
      n_bad++; $display("FAIL mid_rst_req: got req=%b addr=%0d want 1 0", bus.imem_req, bus.imem_addr);
    end
    for (int a = 0; a < 4; a++) exp_q.push_back(a);
    bus.out_ready = 1'b1;
    step();
    wait_drain(30, ok);
    bus.out_ready = 1'b0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL mid_rst_drain: %0d left want 0", exp_q.size()); end
  endtask

`ifdef FQ_STATS_EN
  task automatic test_stats();
    logic [15:0] snap;
    do_reset(1'b0);
    n_cmp++; if (stat_flushes !== 16'd0 || stat_stalls !== 16'd0) begin
      n_bad++; $display("FAIL stats_rst: got f=%0d s=%0d want 0 0", stat_flushes, stat_stalls);
    end
    for (int k = 0; k < 3; k++) begin
      redirect_valid = 1'b1; redirect_pc = 32'd200;
      step();
      redirect_valid = 1'b0;
      step();
    end
    n_cmp++; if (stat_flushes !== 16'd3) begin n_bad++; $display("FAIL stats_flushes: got %0d want 3", stat_flushes); end
    repeat (10) step();
    snap = stat_stalls;
    repeat (10) step();
    n_cmp++; if (stat_stalls !== snap || bus.out_valid !== 1'b1) begin
      n_bad++; $display("FAIL stats_stalls: got %0d v=%b want %0d v=1", stat_stalls, bus.out_valid, snap);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = i;
    // Scoreboard: every accepted head must match the next expected address
    fork
      forever begin
        @(negedge clk1);
        if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++; $display("FAIL unexpected_pop: got ir=%h npc=%h want no delivery", bus.out_ir, bus.out_npc);
          end else begin
            int a;
            a = exp_q.pop_front();
            if (bus.out_ir !== mem[a] || bus.out_npc !== 32'(a + 1)) begin
              n_bad++;
              $display("FAIL pop_data: got ir=%h npc=%h want ir=%h npc=%h", bus.out_ir, bus.out_npc, mem[a], 32'(a + 1));
            end
          end
        end
      end
    join_none
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_hlt();
    test_halt_ext();
    test_reset_mid();
`ifdef FQ_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
